// File: rtl/addsub2comp_seq.sv
// addsub2comp_seq: sequenced N-bit two's-complement adder/subtractor.
// Works by sign-magnitude: load -> magnitudes -> compare -> add/sub -> repack.
// One operation takes five cycles and ends with a one-cycle done pulse.
// Optional build macro ADDSUB_SAT_EN: result_n saturates on overflow instead of wrapping.
module addsub2comp_seq #(
    parameter int unsigned N = 5
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         start_i,
    input  logic         sub_i,
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [N:0]   result_o,
    output logic [N-1:0] result_n_o,
    output logic         overflow_o
);

    localparam logic [N-1:0] OneN  = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N:0]   OneN1 = {{N{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        StIdle,
        StMag,
        StCmp,
        StExec,
        StRes
    } state_e;

    state_e state_q, state_d;

    // Captured operands and signs (sign of b already flipped for subtraction)
    logic [N-1:0] a_q, b_q;
    logic         sgn_a_q, sgn_b_q;
    // Magnitudes; 2^(N-1) fits as an unsigned N-bit value
    logic [N-1:0] mag_a_q, mag_b_q;
    // Ordered operands and the chosen operation
    logic [N-1:0] big_q, small_q;
    logic         op_add_q, res_sgn_q;
    // Unsigned (N+1)-bit magnitude of the result
    logic [N:0]   sum_q;

    logic         done_q, overflow_q;
    logic [N:0]   result_q;
    logic [N-1:0] result_n_q;

    // Combinational helpers for each datapath step
    logic [N-1:0] mag_a_c, mag_b_c;
    logic         a_gt_b_c, b_gt_a_c;
    logic [N:0]   res_c;
    logic         ovf_c;
    logic [N-1:0] res_n_c;

    // Next-state logic: every non-idle state lasts exactly one cycle
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start_i) state_d = StMag;
            StMag:   state_d = StCmp;
            StCmp:   state_d = StExec;
            StExec:  state_d = StRes;
            StRes:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath step functions
    always_comb begin
        mag_a_c  = a_q[N-1] ? (~a_q + OneN) : a_q;
        mag_b_c  = b_q[N-1] ? (~b_q + OneN) : b_q;
        a_gt_b_c = mag_a_q > mag_b_q;
        b_gt_a_c = mag_b_q > mag_a_q;
        res_c    = res_sgn_q ? (~sum_q + OneN1) : sum_q;
        // Exact result is out of N-bit range when its top two bits disagree
        ovf_c    = res_c[N] ^ res_c[N-1];
        res_n_c  = res_c[N-1:0];
`ifdef ADDSUB_SAT_EN
        if (ovf_c) begin
            res_n_c = res_c[N] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        end
`endif
    end

    // Datapath registers, advanced by the sequencer state
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            a_q        <= '0;
            b_q        <= '0;
            sgn_a_q    <= 1'b0;
            sgn_b_q    <= 1'b0;
            mag_a_q    <= '0;
            mag_b_q    <= '0;
            big_q      <= '0;
            small_q    <= '0;
            op_add_q   <= 1'b0;
            res_sgn_q  <= 1'b0;
            sum_q      <= '0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            result_q   <= '0;
            result_n_q <= '0;
        end else begin
            done_q <= (state_q == StRes);
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        a_q     <= a_i;
                        b_q     <= b_i;
                        sgn_a_q <= a_i[N-1];
                        sgn_b_q <= b_i[N-1] ^ sub_i;
                    end
                end
                StMag: begin
                    mag_a_q <= mag_a_c;
                    mag_b_q <= mag_b_c;
                    // No negative zero
                    sgn_a_q <= (mag_a_c == '0) ? 1'b0 : sgn_a_q;
                    sgn_b_q <= (mag_b_c == '0) ? 1'b0 : sgn_b_q;
                end
                StCmp: begin
                    big_q    <= b_gt_a_c ? mag_b_q : mag_a_q;
                    small_q  <= b_gt_a_c ? mag_a_q : mag_b_q;
                    op_add_q <= (sgn_a_q == sgn_b_q);
                    if (sgn_a_q == sgn_b_q) begin
                        res_sgn_q <= sgn_a_q;
                    end else if (a_gt_b_c) begin
                        res_sgn_q <= sgn_a_q;
                    end else if (b_gt_a_c) begin
                        res_sgn_q <= sgn_b_q;
                    end else begin
                        res_sgn_q <= 1'b0;
                    end
                end
                StExec: begin
                    sum_q <= op_add_q ? ({1'b0, big_q} + {1'b0, small_q})
                                      : ({1'b0, big_q} - {1'b0, small_q});
                end
                StRes: begin
                    result_q   <= res_c;
                    result_n_q <= res_n_c;
                    overflow_q <= ovf_c;
                end
                default: ;
            endcase
        end
    end

    assign busy_o     = (state_q != StIdle);
    assign done_o     = done_q;
    assign result_o   = result_q;
    assign result_n_o = result_n_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_addsub2comp_seq.sv
// Self-checking bench for addsub2comp_seq (N=5): directed vector table, randomized
// operations against an integer reference model, back-to-back and reset-abort sequences.
module tb_addsub2comp_seq;

    localparam int N = 5;

    logic         clk_i = 1'b0;
    logic         reset_i, start_i, sub_i;
    logic [N-1:0] a_i, b_i;
    logic         busy_o, done_o, overflow_o;
    logic [N:0]   result_o;
    logic [N-1:0] result_n_o;

    int checks = 0;
    int errors = 0;

    addsub2comp_seq #(.N(N)) dut (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .start_i   (start_i),
        .sub_i     (sub_i),
        .a_i       (a_i),
        .b_i       (b_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .result_o  (result_o),
        .result_n_o(result_n_o),
        .overflow_o(overflow_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         s;
        logic [N:0]   res;
        logic         ovf;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // N-bit view of an exact result: wrap, or clamp when the saturating build is used
    function automatic logic [N-1:0] exp_rn(input logic [N:0] res, input logic ovf);
        logic [N-1:0] r;
        r = res[N-1:0];
`ifdef ADDSUB_SAT_EN
        if (ovf) r = res[N] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
`else
        if (ovf) r = res[N-1:0];
`endif
        return r;
    endfunction

    // Reference: plain integer arithmetic on the signed operands
    task automatic model(input logic [N-1:0] a, input logic [N-1:0] b, input logic s,
                         output logic [N:0] res, output logic ovf);
        int r;
        r   = s ? (int'($signed(a)) - int'($signed(b))) : (int'($signed(a)) + int'($signed(b)));
        res = (N+1)'(r);
        ovf = (r > (2 ** (N - 1)) - 1) || (r < -(2 ** (N - 1)));
    endtask

    // One operation; inputs (including start) are scrambled while busy
    task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic s,
                         input logic [N:0] er, input logic eo, input string nm);
        int edges;
        bit seen;
        logic [N:0] er_hold;
        @(negedge clk_i);
        a_i = a; b_i = b; sub_i = s; start_i = 1'b1;
        @(posedge clk_i); #1;
        check({nm, " busy"}, 32'(busy_o), 32'd1);
        edges = 0;
        seen  = 0;
        while (!seen && edges < 10) begin
            start_i = 1'($urandom);
            a_i     = N'($urandom);
            b_i     = N'($urandom);
            sub_i   = 1'($urandom);
            @(posedge clk_i); #1;
            edges++;
            if (done_o) seen = 1;
        end
        start_i = 1'b0;
        check({nm, " latency"}, 32'(edges), 32'd4);
        check({nm, " result"}, 32'(result_o), 32'(er));
        check({nm, " overflow"}, 32'(overflow_o), 32'(eo));
        check({nm, " result_n"}, 32'(result_n_o), 32'(exp_rn(er, eo)));
        check({nm, " busy after"}, 32'(busy_o), 32'd0);
        er_hold = er;
        @(posedge clk_i); #1;
        check({nm, " done width"}, 32'(done_o), 32'd0);
        check({nm, " hold"}, 32'(result_o), 32'(er_hold));
    endtask

    initial begin
        vec_t vecs[7];
        logic [N-1:0] ra, rb;
        logic         rs, eo;
        logic [N:0]   er;
        logic [N:0]   q_res[$];
        logic         q_ovf[$];

        vecs[0] = '{a: 5'd9,       b: 5'd8,       s: 1'b0, res: 6'b010001, ovf: 1'b1};
        vecs[1] = '{a: 5'b10000,   b: 5'b01111,   s: 1'b1, res: 6'b100001, ovf: 1'b1};
        vecs[2] = '{a: 5'd6,       b: 5'b11010,   s: 1'b0, res: 6'b000000, ovf: 1'b0};
        vecs[3] = '{a: 5'b11001,   b: 5'b11101,   s: 1'b1, res: 6'b111100, ovf: 1'b0};
        vecs[4] = '{a: 5'b10000,   b: 5'b10000,   s: 1'b0, res: 6'b100000, ovf: 1'b1};
        vecs[5] = '{a: 5'b10000,   b: 5'b10000,   s: 1'b1, res: 6'b000000, ovf: 1'b0};
        vecs[6] = '{a: 5'b11101,   b: 5'd7,       s: 1'b0, res: 6'b000100, ovf: 1'b0};

        reset_i = 1'b1; start_i = 1'b0; sub_i = 1'b0; a_i = '0; b_i = '0;
        repeat (3) @(posedge clk_i);
        #1;
        check("reset busy", 32'(busy_o), 32'd0);
        check("reset done", 32'(done_o), 32'd0);
        check("reset result", 32'(result_o), 32'd0);
        check("reset result_n", 32'(result_n_o), 32'd0);
        check("reset overflow", 32'(overflow_o), 32'd0);
        @(negedge clk_i);
        reset_i = 1'b0;

        for (int i = 0; i < 7; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].res, vecs[i].ovf,
                  $sformatf("vec%0d", i));
        end

        // Reset pulsed while the operation is in EXEC
        do_op(5'd9, 5'd8, 1'b0, 6'b010001, 1'b1, "pre-abort");
        @(negedge clk_i);
        a_i = 5'd5; b_i = 5'd3; sub_i = 1'b0; start_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        start_i = 1'b0;
        @(posedge clk_i);
        @(posedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b1;
        @(posedge clk_i); #1;
        check("abort busy", 32'(busy_o), 32'd0);
        check("abort done", 32'(done_o), 32'd0);
        check("abort result", 32'(result_o), 32'd0);
        check("abort overflow", 32'(overflow_o), 32'd0);
        @(negedge clk_i);
        reset_i = 1'b0;
        do_op(5'b11101, 5'd7, 1'b0, 6'd4, 1'b0, "post-abort");

        // Randomized operations against the reference model
        for (int i = 0; i < 40; i++) begin
            ra = N'($urandom);
            rb = N'($urandom);
            rs = 1'($urandom);
            model(ra, rb, rs, er, eo);
            do_op(ra, rb, rs, er, eo, $sformatf("rand%0d", i));
        end

        // start held high with fresh operands every cycle: an op every 5th edge
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_i);
            a_i     = N'($urandom);
            b_i     = N'($urandom);
            sub_i   = 1'($urandom);
            start_i = 1'b1;
            if (k % 5 == 0) begin
                model(a_i, b_i, sub_i, er, eo);
                q_res.push_back(er);
                q_ovf.push_back(eo);
            end
            @(posedge clk_i); #1;
            check($sformatf("b2b done k%0d", k), 32'(done_o), 32'((k % 5) == 4));
            if (k % 5 == 4) begin
                er = q_res.pop_front();
                eo = q_ovf.pop_front();
                check($sformatf("b2b result k%0d", k), 32'(result_o), 32'(er));
                check($sformatf("b2b overflow k%0d", k), 32'(overflow_o), 32'(eo));
                check($sformatf("b2b result_n k%0d", k), 32'(result_n_o),
                      32'(exp_rn(er, eo)));
            end
        end
        @(negedge clk_i);
        start_i = 1'b0;
        @(posedge clk_i); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
